// File: rtl/csa_accum_ctrl_if.sv
// csa_accum_ctrl_if: valid/ready stream carrying one data word per transfer.
//   data  : payload, driven by the master
//   valid : master has a word on data
//   ready : slave takes the word when valid && ready at a clock edge
// Modports: master drives data/valid, slave drives ready.
interface csa_accum_ctrl_if #(
    parameter int unsigned Width = 12
);
    logic [Width-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: folds a frame of Taps 12-bit operands into one sum using a single
// carry-save row, then resolves sum/carry with one carry-propagate add.
//   clk_i   : rising-edge clock
//   rst_i   : synchronous active-high reset, also clears the held result
//   clear_i : synchronous frame abort, drops partial sums and any pending result
//   in_if   : operand stream (slave), in_if.ready is a decode of state and clear_i only
//   out_if  : result stream (master), data is the frame sum mod 4096
//   busy_o  : frame partially accumulated, resolving, or waiting for out_if.ready
//   count_o : operands accepted in the current frame
module csa_accum_ctrl #(
    parameter int unsigned Taps = 8  // legal range 1..255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    csa_accum_ctrl_if.slave    in_if,
    csa_accum_ctrl_if.master   out_if,
    output logic               busy_o,
    output logic [7:0]         count_o
);

    typedef enum logic [1:0] {StIdle, StAcc, StRes, StOut} state_e;

    localparam logic [7:0] LastCount = 8'(Taps);

    state_e      state_q;
    logic [11:0] sum_q;
    logic [11:0] car_q;
    logic [11:0] res_q;
    logic [7:0]  count_q;

    logic [11:0] csa_a;
    logic [11:0] csa_b;
    logic [11:0] csa_s;
    logic [11:0] csa_c;
    logic [11:0] resolved;
    logic        last_op;
    logic        accept;

    always_comb begin
        // A frame always starts from zero partials, whatever the registers hold.
        csa_a    = (state_q == StIdle) ? 12'd0 : sum_q;
        csa_b    = (state_q == StIdle) ? 12'd0 : {car_q[10:0], 1'b0};
        csa_s    = csa_a ^ csa_b ^ in_if.data;
        csa_c    = (csa_a & csa_b) | (csa_a & in_if.data) | (csa_b & in_if.data);
        // car_q[11] would land at bit 12, so dropping it keeps everything mod 4096.
        resolved = sum_q + {car_q[10:0], 1'b0};
        last_op  = (count_q + 8'd1) == LastCount;
    end

    assign in_if.ready  = ((state_q == StIdle) || (state_q == StAcc)) && !clear_i;
    assign accept       = in_if.valid && in_if.ready;
    assign out_if.valid = (state_q == StOut);
    assign out_if.data  = res_q;
    assign busy_o       = (state_q != StIdle);
    assign count_o      = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sum_q   <= '0;
            car_q   <= '0;
            count_q <= '0;
            res_q   <= '0;
        end else if (clear_i) begin
            // res_q is left alone; it is invisible once out_if.valid drops.
            state_q <= StIdle;
            sum_q   <= '0;
            car_q   <= '0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StAcc: begin
                    if (accept) begin
                        sum_q   <= csa_s;
                        car_q   <= csa_c;
                        count_q <= count_q + 8'd1;
                        state_q <= last_op ? StRes : StAcc;
                    end
                end
                StRes: begin
                    res_q   <= resolved;
                    sum_q   <= '0;
                    car_q   <= '0;
                    count_q <= '0;
                    state_q <= StOut;
                end
                StOut: begin
                    if (out_if.ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb_csa_accum_ctrl: directed scenarios plus a randomized run against a frame-sum model,
// on a Taps=4 instance and a Taps=1 instance.
module tb_csa_accum_ctrl;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       busy;
    logic [7:0] count;
    logic       busy1;
    logic [7:0] count1;
    logic       clr1;

    int errors = 0;
    int checks = 0;

    csa_accum_ctrl_if #(.Width(12)) in_if ();
    csa_accum_ctrl_if #(.Width(12)) out_if ();
    csa_accum_ctrl_if #(.Width(12)) in1_if ();
    csa_accum_ctrl_if #(.Width(12)) out1_if ();

    csa_accum_ctrl #(.Taps(4)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clr),
        .in_if   (in_if),
        .out_if  (out_if),
        .busy_o  (busy),
        .count_o (count)
    );

    csa_accum_ctrl #(.Taps(1)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clr1),
        .in_if   (in1_if),
        .out_if  (out1_if),
        .busy_o  (busy1),
        .count_o (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic abort();
        in_if.valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_if.ready); end
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_if.valid); end
        checks++; if (out_if.data !== 12'h000) begin errors++; $display("FAIL reset_out_data: got %0h want 0", out_if.data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        abort();
        out_if.ready = 1'b1;
        in_if.valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_if.data = 12'(i);
            tick();
            checks++; if (count !== 8'(i)) begin errors++; $display("FAIL basic_count: got %0d want %0d", count, i); end
        end
        in_if.data = 12'd77;  // must not be taken while resolving or presenting
        checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL basic_res_ready: got %0b want 0", in_if.ready); end
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL basic_res_valid: got %0b want 0", out_if.valid); end
        tick();
        checks++; if (out_if.valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b want 1", out_if.valid); end
        checks++; if (out_if.data !== 12'd10) begin errors++; $display("FAIL basic_out_data: got %0d want 10", out_if.data); end
        tick();
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b want 0", out_if.valid); end
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL basic_idle_count: got %0d want 0", count); end
        checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready: got %0b want 1", in_if.ready); end
        tick();
        checks++; if (count !== 8'd1) begin errors++; $display("FAIL basic_next_frame: got %0d want 1", count); end
    endtask

    task automatic test_wrap();
        abort();
        out_if.ready = 1'b1;
        in_if.valid = 1'b1;
        repeat (4) begin
            in_if.data = 12'hFFF;
            tick();
        end
        in_if.valid = 1'b0;
        tick();
        checks++; if (out_if.data !== 12'hFFC || out_if.valid !== 1'b1) begin errors++; $display("FAIL wrap_fff: got %0h/%0b want ffc/1", out_if.data, out_if.valid); end
        tick();
        in_if.valid = 1'b1;
        in_if.data = 12'h800; tick();
        in_if.data = 12'h800; tick();
        in_if.data = 12'h001; tick();
        in_if.data = 12'h000; tick();
        in_if.valid = 1'b0;
        tick();
        checks++; if (out_if.data !== 12'h001 || out_if.valid !== 1'b1) begin errors++; $display("FAIL wrap_800: got %0h/%0b want 1/1", out_if.data, out_if.valid); end
        tick();
    endtask

    task automatic test_backpressure();
        abort();
        out_if.ready = 1'b0;
        in_if.valid = 1'b1;
        in_if.data = 12'd1;
        repeat (4) tick();
        tick();
        in_if.data = 12'h0AB;
        for (int k = 0; k < 5; k++) begin
            checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0b want 0", in_if.ready); end
            checks++; if (out_if.valid !== 1'b1 || out_if.data !== 12'd4) begin errors++; $display("FAIL bp_hold: got %0h/%0b want 4/1", out_if.data, out_if.valid); end
            tick();
        end
        out_if.ready = 1'b1;
        tick();
        out_if.ready = 1'b0;
        checks++; if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1 || count !== 8'd0) begin errors++; $display("FAIL bp_release: got v=%0b r=%0b c=%0d want 0 1 0", out_if.valid, in_if.ready, count); end
        tick();
        checks++; if (count !== 8'd1 || busy !== 1'b1) begin errors++; $display("FAIL bp_pending_accept: got c=%0d b=%0b want 1 1", count, busy); end
        in_if.data = 12'd0;
        repeat (3) tick();
        in_if.valid = 1'b0;
        tick();
        checks++; if (out_if.data !== 12'h0AB) begin errors++; $display("FAIL bp_frame_sum: got %0h want ab", out_if.data); end
        out_if.ready = 1'b1;
        tick();
    endtask

    task automatic test_gaps();
        abort();
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_if.valid = 1'b1;
            in_if.data = 12'(5 + i);
            tick();
            in_if.valid = 1'b0;
            if (i < 3) begin
                repeat (3) begin
                    checks++; if (count !== 8'(i + 1)) begin errors++; $display("FAIL gap_count: got %0d want %0d", count, i + 1); end
                    tick();
                end
            end
        end
        tick();
        checks++; if (out_if.data !== 12'd26 || out_if.valid !== 1'b1) begin errors++; $display("FAIL gap_sum: got %0d/%0b want 26/1", out_if.data, out_if.valid); end
        tick();
    endtask

    task automatic test_clear();
        abort();
        out_if.ready = 1'b1;
        in_if.valid = 1'b1;
        in_if.data = 12'd100; tick();
        in_if.data = 12'd200; tick();
        checks++; if (count !== 8'd2) begin errors++; $display("FAIL clear_pre_count: got %0d want 2", count); end
        clr = 1'b1;
        in_if.data = 12'd55;
        #1;
        checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %0b want 0", in_if.ready); end
        tick();
        clr = 1'b0;
        checks++; if (count !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL clear_abort: got c=%0d b=%0b want 0 0", count, busy); end
        in_if.data = 12'd9;
        repeat (4) tick();
        in_if.valid = 1'b0;
        tick();
        checks++; if (out_if.data !== 12'd36 || out_if.valid !== 1'b1) begin errors++; $display("FAIL clear_sum: got %0d/%0b want 36/1", out_if.data, out_if.valid); end
        out_if.ready = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (out_if.valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_out_drop: got v=%0b b=%0b want 0 0", out_if.valid, busy); end
    endtask

    task automatic test_rst();
        for (int phase = 0; phase < 2; phase++) begin
            abort();
            out_if.ready = 1'b0;
            in_if.valid = 1'b1;
            in_if.data = 12'd3;
            repeat (4) tick();
            in_if.valid = 1'b0;
            if (phase == 0) begin
                checks++; if (count !== 8'd4 || busy !== 1'b1) begin errors++; $display("FAIL rst_in_res_pre: got c=%0d b=%0b want 4 1", count, busy); end
            end else begin
                tick();
                checks++; if (out_if.data !== 12'd12 || out_if.valid !== 1'b1) begin errors++; $display("FAIL rst_in_out_pre: got %0d/%0b want 12/1", out_if.data, out_if.valid); end
            end
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checks++; if (out_if.valid !== 1'b0 || out_if.data !== 12'd0) begin errors++; $display("FAIL rst_out_%0d: got %0h/%0b want 0/0", phase, out_if.data, out_if.valid); end
            checks++; if (count !== 8'd0 || busy !== 1'b0 || in_if.ready !== 1'b1) begin errors++; $display("FAIL rst_state_%0d: got c=%0d b=%0b r=%0b want 0 0 1", phase, count, busy, in_if.ready); end
        end
    endtask

    task automatic test_taps1();
        in1_if.valid = 1'b1;
        in1_if.data = 12'h123;
        out1_if.ready = 1'b1;
        checks++; if (in1_if.ready !== 1'b1) begin errors++; $display("FAIL t1_ready: got %0b want 1", in1_if.ready); end
        tick();
        in1_if.valid = 1'b0;
        checks++; if (count1 !== 8'd1 || busy1 !== 1'b1 || out1_if.valid !== 1'b0) begin errors++; $display("FAIL t1_res: got c=%0d b=%0b v=%0b want 1 1 0", count1, busy1, out1_if.valid); end
        tick();
        checks++; if (out1_if.valid !== 1'b1 || out1_if.data !== 12'h123) begin errors++; $display("FAIL t1_out: got %0h/%0b want 123/1", out1_if.data, out1_if.valid); end
        tick();
        checks++; if (out1_if.valid !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL t1_idle: got v=%0b b=%0b want 0 0", out1_if.valid, busy1); end
    endtask

    // Model: a frame is the next 4 accepted operands; their plain integer sum mod 4096 appears
    // one cycle after the 4th accept and stays until taken. phase: 0 collecting, 1 resolving,
    // 2 presenting.
    task automatic test_random();
        int          phase = 0;
        int          n = 0;
        int          total = 0;
        logic [11:0] exp_res = '0;
        logic        exp_rdy;
        abort();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_if.valid  = ($urandom_range(0, 3) != 0);
            in_if.data   = 12'($urandom);
            out_if.ready = ($urandom_range(0, 2) != 0);
            clr          = ($urandom_range(0, 39) == 0);
            #1;
            exp_rdy = (phase == 0) && !clr;
            checks++; if (in_if.ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready @%0d: got %0b want %0b", cyc, in_if.ready, exp_rdy); end
            checks++; if (out_if.valid !== (phase == 2)) begin errors++; $display("FAIL rnd_valid @%0d: got %0b want %0b", cyc, out_if.valid, phase == 2); end
            checks++; if (busy !== (phase != 0 || n != 0)) begin errors++; $display("FAIL rnd_busy @%0d: got %0b want %0b", cyc, busy, phase != 0 || n != 0); end
            checks++; if (count !== 8'((phase == 2) ? 0 : n)) begin errors++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, count, (phase == 2) ? 0 : n); end
            if (phase == 2) begin
                checks++; if (out_if.data !== exp_res) begin errors++; $display("FAIL rnd_data @%0d: got %0h want %0h", cyc, out_if.data, exp_res); end
            end
            if (clr) begin
                phase = 0; n = 0; total = 0;
            end else if (phase == 0) begin
                if (in_if.valid) begin
                    total += int'(in_if.data);
                    n++;
                    if (n == 4) phase = 1;
                end
            end else if (phase == 1) begin
                exp_res = 12'(total % 4096);
                total = 0; n = 0; phase = 2;
            end else if (out_if.ready) begin
                phase = 0;
            end
            tick();
        end
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        clr1 = 1'b0;
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b0;
        in1_if.valid = 1'b0;
        in1_if.data = '0;
        out1_if.ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_gaps();
        test_clear();
        test_rst();
        test_taps1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
